// File: rtl/bus_interconnect_rr_if.sv
// Endpoint-side bundle of the round-robin shared bus: send handshake, delivery and status.
// The interconnect takes the slave modport, the endpoints (or a bench) the master modport.
interface bus_interconnect_rr_if #(
  parameter int N_PORTS = 3,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
);
  logic [N_PORTS-1:0]        send_valid;
  logic [N_PORTS*DATA_W-1:0] send_data;
  logic [N_PORTS*ID_W-1:0]   send_dest;
  logic [N_PORTS-1:0]        send_ready;
  logic [N_PORTS-1:0]        recv_valid;
  logic [DATA_W-1:0]         recv_data;
  logic [ID_W-1:0]           recv_src;
  logic [N_PORTS-1:0]        recv_ack;
  logic                      busy;
  logic                      err;

  modport master (
    output send_valid, send_data, send_dest, recv_ack,
    input  send_ready, recv_valid, recv_data, recv_src, busy, err
  );

  modport slave (
    input  send_valid, send_data, send_dest, recv_ack,
    output send_ready, recv_valid, recv_data, recv_src, busy, err
  );
endinterface

// File: rtl/bus_interconnect_rr.sv
// Mux-based shared bus for N_PORTS endpoints: round-robin arbitration, unicast/broadcast delivery
// with per-receiver ack. Define ACK_TIMEOUT_EN to abort deliveries that stay unacked for TIMEOUT cycles.
module bus_interconnect_rr #(
  parameter int N_PORTS = 3,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input logic                  clk,
  input logic                  rst_n,
  bus_interconnect_rr_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, DELIVER = 1'b1} state_t;

  localparam logic [ID_W-1:0] LAST_PORT = ID_W'(N_PORTS - 1);
  localparam logic [ID_W-1:0] BCAST_ID  = {ID_W{1'b1}};

  state_t              state_r;
  state_t              state_nxt_s;
  logic [N_PORTS-1:0]  pending_r;
  logic [N_PORTS-1:0]  pending_nxt_s;
  logic [N_PORTS-1:0]  grant_s;
  logic [N_PORTS-1:0]  mask_s;
  logic [ID_W-1:0]     last_grant_r;
  logic [ID_W-1:0]     win_s;
  logic [ID_W-1:0]     dest_s;
  logic [ID_W-1:0]     recv_src_r;
  logic [DATA_W-1:0]   data_s;
  logic [DATA_W-1:0]   recv_data_r;
  logic                found_s;
  logic                hit_s;
  int                  idx_s;
  logic                dest_ok_s;
  logic                accept_s;
  logic                timeout_hit_s;
  logic                err_r;

  if (N_PORTS < 2 || N_PORTS > (2 ** ID_W) - 1) begin : g_bad_ports
    $error("bus_interconnect_rr: N_PORTS out of range for ID_W");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_interconnect_rr: TIMEOUT out of range");
  end

  // Returns {dest_ok, pending_mask}; broadcast excludes the sender, unknown IDs give ok=0.
  function automatic logic [N_PORTS:0] decode_dest(input logic [ID_W-1:0] dest,
                                                   input logic [ID_W-1:0] src);
    logic [N_PORTS-1:0] m;
    logic               ok;
    m  = '0;
    ok = 1'b0;
    if (dest == BCAST_ID) begin
      ok = 1'b1;
      for (int i = 0; i < N_PORTS; i++) m[i] = (i != int'(src));
    end else if (int'(dest) < N_PORTS) begin
      ok = 1'b1;
      for (int i = 0; i < N_PORTS; i++) m[i] = (i == int'(dest));
    end else begin
      ok = 1'b0;
      m  = '0;
    end
    return {ok, m};
  endfunction

  // Round-robin search starting one past the last granted port.
  always_comb begin
    grant_s = '0;
    win_s   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = 0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx_s          = (int'(last_grant_r) + k) % N_PORTS;
      hit_s          = bus.send_valid[idx_s] & ~found_s;
      grant_s[idx_s] = grant_s[idx_s] | hit_s;
      win_s          = hit_s ? ID_W'(idx_s) : win_s;
      found_s        = found_s | hit_s;
    end
  end

  // Winner's payload/destination and the resulting delivery mask.
  always_comb begin
    data_s              = bus.send_data[int'(win_s)*DATA_W +: DATA_W];
    dest_s              = bus.send_dest[int'(win_s)*ID_W +: ID_W];
    {dest_ok_s, mask_s} = decode_dest(dest_s, win_s);
    accept_s            = (state_r == IDLE) && found_s;
  end

`ifdef ACK_TIMEOUT_EN
  logic [7:0] tmo_cnt_r;

  // Counts cycles spent in DELIVER; held at zero in IDLE so every entry starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_r == DELIVER) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= 8'd0;
    end
  end

  assign timeout_hit_s = (state_r == DELIVER) && (tmo_cnt_r == 8'(TIMEOUT - 1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; a timeout abort wins over any acks on the same edge.
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    case (state_r)
      IDLE: begin
        if (accept_s && dest_ok_s) begin
          state_nxt_s   = DELIVER;
          pending_nxt_s = mask_s;
        end else begin
          state_nxt_s   = IDLE;
          pending_nxt_s = '0;
        end
      end
      DELIVER: begin
        if (timeout_hit_s) begin
          state_nxt_s   = IDLE;
          pending_nxt_s = '0;
        end else if ((pending_r & ~bus.recv_ack) == '0) begin
          state_nxt_s   = IDLE;
          pending_nxt_s = '0;
        end else begin
          state_nxt_s   = DELIVER;
          pending_nxt_s = pending_r & ~bus.recv_ack;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        pending_nxt_s = '0;
      end
    endcase
  end

  // FSM outputs: grants only in IDLE, busy only in DELIVER.
  always_comb begin
    bus.send_ready = '0;
    bus.busy       = 1'b0;
    case (state_r)
      IDLE: begin
        bus.send_ready = grant_s;
        bus.busy       = 1'b0;
      end
      DELIVER: begin
        bus.send_ready = '0;
        bus.busy       = 1'b1;
      end
      default: begin
        bus.send_ready = '0;
        bus.busy       = 1'b0;
      end
    endcase
  end

  // Delivery registers, round-robin pointer and the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r    <= '0;
      last_grant_r <= LAST_PORT;
      recv_data_r  <= '0;
      recv_src_r   <= '0;
      err_r        <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      err_r     <= (accept_s & ~dest_ok_s) | timeout_hit_s;
      if (accept_s) begin
        last_grant_r <= win_s;
        recv_data_r  <= data_s;
        recv_src_r   <= win_s;
      end else begin
        last_grant_r <= last_grant_r;
        recv_data_r  <= recv_data_r;
        recv_src_r   <= recv_src_r;
      end
    end
  end

  assign bus.recv_valid = pending_r;
  assign bus.recv_data  = recv_data_r;
  assign bus.recv_src   = recv_src_r;
  assign bus.err        = err_r;

endmodule
